// File: rtl/ws2812_pkg.sv
// Shared WS2812 protocol constants, error codes and receiver state encoding.
// Timing values are in 50 MHz clock cycles and are common to the transmitter.
package ws2812_pkg;

  localparam int unsigned T0H    = 20;
  localparam int unsigned T1H    = 40;
  localparam int unsigned T0L    = 42;
  localparam int unsigned T1L    = 22;
  localparam int unsigned TLATCH = 2500;

  localparam logic [1:0] ERR_GLITCH  = 2'b01;
  localparam logic [1:0] ERR_STUCK   = 2'b10;
  localparam logic [1:0] ERR_PARTIAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StStuck
  } rx_state_e;

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer for the WS2812 data pin with rise/fall strobes.
// Rises are ignored until a genuinely sampled low has been seen after reset.
module ws2812_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic din_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic       s1_q, s2_q, prev_q;
  logic [1:0] vld_q, vld_d;
  logic       armed_q, armed_d;

  // vld_q[1] marks s2_q as holding a real pin sample rather than its reset value.
  always_comb begin
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & ~s2_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= din_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end

  assign din_s_o = s2_q;
  assign rise_o  = s2_q & ~prev_q & armed_q;
  assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures synchronized high widths, assembles MSB-first GRB
// pixels, and flags the low-time latch gap, glitches and stuck-high pulses.
module ws2812_rx #(
  parameter int unsigned T_GLITCH     = 5,
  parameter int unsigned T_BIT_THRESH = 30,
  parameter int unsigned T_HIGH_MAX   = 75,
  parameter int unsigned T_LATCH      = 2500,
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned IDX_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             latch,
  output logic [IDX_W-1:0] frame_len,
  output logic             err,
  output logic [1:0]       err_code
);
  import ws2812_pkg::*;

  localparam logic [CNT_W-1:0] GlitchW   = CNT_W'(T_GLITCH);
  localparam logic [CNT_W-1:0] BitW      = CNT_W'(T_BIT_THRESH);
  localparam logic [CNT_W-1:0] HighLast  = CNT_W'(T_HIGH_MAX - 1);
  localparam logic [CNT_W-1:0] LatchLast = CNT_W'(T_LATCH - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  logic din_s, rise, fall;

  ws2812_sync u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .din_i   (din),
    .din_s_o (din_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [23:0]      pixel_data_q, pixel_data_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0] pixel_index_q, pixel_index_d;
  logic             latch_q, latch_d;
  logic [IDX_W-1:0] frame_len_q, frame_len_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  // cnt_q holds the number of cycles the current level has lasted before this one,
  // so at a falling strobe it equals the high width.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    latch_d       = 1'b0;
    frame_len_d   = frame_len_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    if (rise || fall) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          if (cnt_q < GlitchW) begin
            err_d      = 1'b1;
            err_code_d = ERR_GLITCH;
            bit_cnt_d  = '0;
          end else begin
            shift_d = {shift_q[22:0], (cnt_q >= BitW)};
            if (bit_cnt_q == 5'd23) begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = {shift_q[22:0], (cnt_q >= BitW)};
              pixel_index_d = idx_q;
              idx_d         = idx_q + 1'b1;
              bit_cnt_d     = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (din_s && cnt_q == HighLast) begin
          // This cycle is the T_HIGH_MAX-th high cycle.
          state_d    = StStuck;
          err_d      = 1'b1;
          err_code_d = ERR_STUCK;
          bit_cnt_d  = '0;
        end
      end
      StStuck: begin
        if (fall) state_d = StLow;
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
        end else if (cnt_q == LatchLast) begin
          state_d     = StIdle;
          latch_d     = 1'b1;
          frame_len_d = idx_q;
          idx_d       = '0;
          bit_cnt_d   = '0;
          if (bit_cnt_q != '0) begin
            err_d      = 1'b1;
            err_code_d = ERR_PARTIAL;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      idx_q         <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      latch_q       <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      latch_q       <= latch_d;
      frame_len_q   <= frame_len_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign latch       = latch_q;
  assign frame_len   = frame_len_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
